ultrasonido_ctrl: RTL and testbench

- Drives an HC-SR04-class ultrasonic ranger and produces the `distancia` presence flag consumed by the LCD message stage.
- Periodically fires a trigger pulse, then times the echo width. The width is converted to whole centimetres by a counter, with no divider.
- The result is compared against a threshold: `distancia`=0 means an object is within range, so the display wakes up.
- One result is produced per measurement period; timeouts are reported as "far".

---
 rtl/ultrasonido_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ultrasonido_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonido_ctrl.sv
// HC-SR04 ranger controller: periodic trigger, echo-width to centimetres, presence flag.
// Latency: the result registers one cycle after echo_s falls. There is no backpressure, and valid is a single-cycle pulse.
// ULTRA_FILTER_EN: distancia changes only after FILTER_N agreeing results.
module ultrasonido_ctrl #(
    parameter int TRIG_CYCLES   = 500,
    parameter int PERIOD_CYCLES = 3000000,
    parameter int ECHO_TIMEOUT  = 1500000,
    parameter int CM_DIV        = 2900,
    parameter int THRESH_CM     = 20,
    parameter int DIST_BITS     = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 echo,
    output logic                 trigger,
    output logic                 distancia,
    output logic [DIST_BITS-1:0] dist_cm,
    output logic                 valid,
    output logic                 timeout
);
    localparam int CW = $clog2(PERIOD_CYCLES + ECHO_TIMEOUT + TRIG_CYCLES + 1);
    localparam int SW = $clog2(CM_DIV + 1);

    typedef enum logic [1:0] {TRIG, WAIT_RISE, MEASURE, HOLD} state_t;

    state_t               state, state_n;
    logic                 echo_m, echo_s;
    logic [CW-1:0]        cnt, cnt_n, period_cnt;
    logic [SW-1:0]        sub_cnt, sub_n, step_sub;
    logic [DIST_BITS-1:0] cm_acc, acc_n, step_acc;
    logic                 rec_ok, rec_to, raw_far;

    // One echo-high cycle: advance the sub-counter, carry into the saturating cm count.
    always_comb begin
        step_sub = sub_cnt + 1'b1;
        step_acc = cm_acc;
        if (sub_cnt == SW'(CM_DIV - 1)) begin
            step_sub = '0;
            if (cm_acc != '1) step_acc = cm_acc + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        sub_n   = sub_cnt;
        acc_n   = cm_acc;
        rec_ok  = 1'b0;
        rec_to  = 1'b0;
        case (state)
            TRIG: begin
                // After reset the trigger register is still low for one cycle; count only high cycles.
                if (!trigger) begin
                    cnt_n = '0;
                end else if (cnt == CW'(TRIG_CYCLES - 1)) begin
                    state_n = WAIT_RISE;
                    cnt_n   = '0;
                end
            end
            WAIT_RISE: begin
                if (echo_s) begin
                    state_n = MEASURE;
                    cnt_n   = CW'(1);
                    sub_n   = step_sub;
                    acc_n   = step_acc;
                end else if (cnt == CW'(ECHO_TIMEOUT)) begin
                    rec_to  = 1'b1;
                    state_n = HOLD;
                end
            end
            MEASURE: begin
                if (!echo_s) begin
                    rec_ok  = 1'b1;
                    state_n = HOLD;
                end else if (cnt == CW'(ECHO_TIMEOUT)) begin
                    rec_to  = 1'b1;
                    state_n = HOLD;
                end else begin
                    sub_n = step_sub;
                    acc_n = step_acc;
                end
            end
            HOLD: begin
                cnt_n = '0;
                if (period_cnt == CW'(PERIOD_CYCLES - 1) && !echo_s) begin
                    state_n = TRIG;
                    sub_n   = '0;
                    acc_n   = '0;
                end
            end
            default: state_n = TRIG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            echo_m     <= 1'b0;
            echo_s     <= 1'b0;
            state      <= TRIG;
            cnt        <= '0;
            sub_cnt    <= '0;
            cm_acc     <= '0;
            period_cnt <= '0;
            trigger    <= 1'b0;
            dist_cm    <= '1;
            timeout    <= 1'b0;
            valid      <= 1'b0;
        end else begin
            echo_m  <= echo;
            echo_s  <= echo_m;
            state   <= state_n;
            cnt     <= cnt_n;
            sub_cnt <= sub_n;
            cm_acc  <= acc_n;
            trigger <= (state_n == TRIG);
            if (state_n == TRIG && !trigger) begin
                period_cnt <= '0;
            end else if (period_cnt != CW'(PERIOD_CYCLES - 1)) begin
                period_cnt <= period_cnt + 1'b1;
            end
            valid <= rec_ok | rec_to;
            if (rec_ok) begin
                dist_cm <= cm_acc;
                timeout <= 1'b0;
            end else if (rec_to) begin
                dist_cm <= '1;
                timeout <= 1'b1;
            end
        end
    end

    assign raw_far = rec_to | (cm_acc >= DIST_BITS'(THRESH_CM));

`ifdef ULTRA_FILTER_EN
    localparam int FILTER_N = 3;
    logic [1:0] agree;

    always_ff @(posedge clk) begin
        if (!reset) begin
            distancia <= 1'b1;
            agree     <= '0;
        end else if (rec_ok | rec_to) begin
            if (raw_far == distancia) begin
                agree <= '0;
            end else if (agree == 2'(FILTER_N - 1)) begin
                distancia <= raw_far;
                agree     <= '0;
            end else begin
                agree <= agree + 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!reset) begin
            distancia <= 1'b1;
        end else if (rec_ok | rec_to) begin
            distancia <= raw_far;
        end
    end
`endif

endmodule

// File: tb/tb_ultrasonido_ctrl.sv
// Scoreboarded bench for ultrasonido_ctrl using the reduced test-plan parameters.
`timescale 1ns/1ps
module tb_ultrasonido_ctrl;
    localparam int TRIG = 5;
    localparam int PER  = 2000;
    localparam int TO   = 800;
    localparam int CMD  = 10;
    localparam int TH   = 20;
    localparam int DB   = 9;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          echo  = 1'b0;
    logic          trigger, distancia, valid, timeout;
    logic [DB-1:0] dist_cm;

    ultrasonido_ctrl #(
        .TRIG_CYCLES(TRIG), .PERIOD_CYCLES(PER), .ECHO_TIMEOUT(TO),
        .CM_DIV(CMD), .THRESH_CM(TH), .DIST_BITS(DB)
    ) dut (
        .clk(clk), .reset(reset), .echo(echo), .trigger(trigger),
        .distancia(distancia), .dist_cm(dist_cm), .valid(valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DB-1:0] d;
        logic          far;
        logic          to;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rise_cyc[$];
    int   trig_w = 0;
    int   last_trig_w = 0;
    logic trig_prev = 1'b0;
`ifdef ULTRA_FILTER_EN
    logic model_far = 1'b1;
    int   model_agree = 0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int cm, input bit to);
        res_t e;
        bit   raw_far;
        raw_far = to || (cm >= TH);
        e.d  = to ? {DB{1'b1}} : DB'(cm);
        e.to = to;
`ifdef ULTRA_FILTER_EN
        if (raw_far == model_far) model_agree = 0;
        else if (model_agree == 2) begin
            model_far   = raw_far;
            model_agree = 0;
        end else model_agree++;
        e.far = model_far;
`else
        e.far = raw_far;
`endif
        exp_q.push_back(e);
    endtask

    // Trigger monitor: rise times and the width of the last completed pulse.
    always @(negedge clk) begin
        if (trigger && !trig_prev) rise_cyc.push_back(cyc);
        if (trigger) trig_w++;
        else if (trig_prev) begin
            last_trig_w = trig_w;
            trig_w = 0;
        end
        trig_prev = trigger;
    end

    // Result monitor: every valid pulse is checked against the oldest expectation.
    always @(negedge clk) begin
        if (valid) begin
            if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                res_t e;
                e = exp_q.pop_front();
                chk("dist_cm", int'(dist_cm), int'(e.d));
                chk("distancia", int'(distancia), int'(e.far));
                chk("timeout", int'(timeout), int'(e.to));
            end
        end
    end

    task automatic wait_trig_fall(input string name);
        int n = 0;
        while (trigger == 1'b0 && n < 3 * PER) begin @(negedge clk); n++; end
        while (trigger == 1'b1 && n < 3 * PER) begin @(negedge clk); n++; end
        if (n >= 3 * PER) chk({name, "_trigger_wait"}, 0, 1);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 5 * PER) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) begin
            chk({name, "_missing_valid"}, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic measure(input string name, input int width, input int cm, input bit to);
        wait_trig_fall(name);
        repeat (3) @(negedge clk);
        push_exp(cm, to);
        echo = 1'b1;
        repeat (width) @(negedge clk);
        echo = 1'b0;
        wait_drain(name);
    endtask

    initial begin
        int n;
        int fall_cyc;
        int nrise;
        repeat (3) @(negedge clk);
        chk("rst_trigger", int'(trigger), 0);
        chk("rst_distancia", int'(distancia), 1);
        chk("rst_dist_cm", int'(dist_cm), 511);
        chk("rst_valid", int'(valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        reset = 1'b1;

        // Idle echo: wait-for-rise timeout, trigger width and period.
        push_exp(0, 1'b1);
        wait_drain("idle_timeout");
        chk("trig_width", last_trig_w, TRIG);
        n = 0;
        while (rise_cyc.size() < 2 && n < 3 * PER) begin @(negedge clk); n++; end
        if (rise_cyc.size() < 2) chk("second_trigger_seen", rise_cyc.size(), 2);
        else chk("trig_period", rise_cyc[1] - rise_cyc[0], PER);

        measure("w150", 150, 15, 1'b0);
        measure("w200", 200, 20, 1'b0);
        measure("w199", 199, 19, 1'b0);
        measure("w5",   5,   0,  1'b0);

        // Echo stuck high past both timeout and period: trigger waits for the fall.
        wait_trig_fall("stuck");
        repeat (3) @(negedge clk);
        push_exp(0, 1'b1);
        echo = 1'b1;
        repeat (2100) @(negedge clk);
        chk("stuck_drained", exp_q.size(), 0);
        nrise = rise_cyc.size();
        fall_cyc = cyc;
        echo = 1'b0;
        n = 0;
        while (rise_cyc.size() == nrise && n < 3 * PER) begin @(negedge clk); n++; end
        if (rise_cyc.size() == nrise) chk("stuck_rise_seen", 0, 1);
        else begin
            chk("stuck_rise_delay", rise_cyc[nrise] - fall_cyc, 3);
            chk("stuck_gap_over_period", int'(rise_cyc[nrise] - rise_cyc[nrise-1] > PER), 1);
        end

        // Agreement sequence 10, 30, 10, 10, 10 cm.
        measure("f10a", 100, 10, 1'b0);
        measure("f30",  300, 30, 1'b0);
        measure("f10b", 100, 10, 1'b0);
        measure("f10c", 100, 10, 1'b0);
        measure("f10d", 100, 10, 1'b0);

        // Reset during MEASURE aborts with no result and re-arms immediately.
        wait_trig_fall("rst_mid");
        repeat (3) @(negedge clk);
        echo = 1'b1;
        repeat (50) @(negedge clk);
        reset = 1'b0;
`ifdef ULTRA_FILTER_EN
        model_far   = 1'b1;
        model_agree = 0;
`endif
        @(negedge clk);
        chk("mid_rst_trigger", int'(trigger), 0);
        chk("mid_rst_distancia", int'(distancia), 1);
        chk("mid_rst_dist_cm", int'(dist_cm), 511);
        chk("mid_rst_timeout", int'(timeout), 0);
        chk("mid_rst_valid", int'(valid), 0);
        echo = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rearm_trigger", int'(trigger), 1);
        repeat (200) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
